// File: rtl/gpio_pad_ctrl_if.sv
// Register bus between the SoC fabric and gpio_pad_ctrl: request held until a one-cycle ack.
interface gpio_pad_ctrl_if;
    logic        i_sel;
    logic        i_we;
    logic [2:0]  i_addr;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;
    logic        o_ack;

    modport master (output i_sel, i_we, i_addr, i_wdata, input o_rdata, o_ack);
    modport slave  (input i_sel, i_we, i_addr, i_wdata, output o_rdata, o_ack);
endinterface

// File: rtl/gpio_pad_ctrl.sv
// GPIO controller: pad data/OE registers, synchronised (optionally debounced) inputs, edge IRQs.
// Define GPIO_DEBOUNCE_EN to insert the per-pin debounce filter after the synchroniser.
module gpio_pad_ctrl #(
    parameter int NUM_PINS    = 24,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 8,
    parameter int DEB_CYCLES  = 100
) (
    input  logic                clk,
    input  logic                reset_n,
    gpio_pad_ctrl_if.slave      bus,
    input  logic [NUM_PINS-1:0] i_gpio,
    output logic [NUM_PINS-1:0] o_gpio,
    output logic [NUM_PINS-1:0] en_gpio,
    output logic                o_irq
);
    localparam int GW = $clog2(SYNC_STAGES + 2);
    localparam logic [GW-1:0] GUARD_END = GW'(SYNC_STAGES + 1);

    if (NUM_PINS < 1 || NUM_PINS > 32) begin : g_chk_pins
        $error("NUM_PINS out of range");
    end
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (DEB_CYCLES < 1 || DEB_CYCLES > (2**DEB_W) - 1) begin : g_chk_deb
        $error("DEB_CYCLES out of range");
    end

    logic [NUM_PINS-1:0] data_out_q, data_out_d;
    logic [NUM_PINS-1:0] dir_q, dir_d;
    logic [NUM_PINS-1:0] irq_en_q, irq_en_d;
    logic [NUM_PINS-1:0] rise_q, rise_d;
    logic [NUM_PINS-1:0] fall_q, fall_d;
    logic [NUM_PINS-1:0] status_q, status_d;
    logic [NUM_PINS-1:0] prev_q;
    logic [SYNC_STAGES-1:0][NUM_PINS-1:0] sync_q;
    logic [GW-1:0]       guard_q;
    logic                ack_q, irq_q;
    logic [31:0]         rdata_q, rdata_d;
    logic [NUM_PINS-1:0] filt, wpins, edge_set, clr;
    logic                accept, wr;
    logic                unused_wdata;

    assign unused_wdata = ^bus.i_wdata;
    assign wpins  = bus.i_wdata[NUM_PINS-1:0];
    assign accept = bus.i_sel & ~ack_q;
    assign wr     = accept & bus.i_we;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= i_gpio;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    logic [NUM_PINS-1:0]            filt_q;
    logic [NUM_PINS-1:0][DEB_W-1:0] deb_q;

    // Any cycle where sync agrees with filt restarts the count, so glitches never accumulate.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            filt_q <= '0;
            deb_q  <= '0;
        end else begin
            for (int p = 0; p < NUM_PINS; p++) begin
                if (sync_q[SYNC_STAGES-1][p] == filt_q[p]) begin
                    deb_q[p] <= '0;
                end else if (deb_q[p] == DEB_W'(DEB_CYCLES - 1)) begin
                    filt_q[p] <= ~filt_q[p];
                    deb_q[p]  <= '0;
                end else begin
                    deb_q[p] <= deb_q[p] + 1'b1;
                end
            end
        end
    end
    assign filt = filt_q;
`else
    assign filt = sync_q[SYNC_STAGES-1];
`endif

    // Edges are ignored until the synchroniser has flushed its reset zeros.
    assign edge_set = (guard_q == GUARD_END) ?
                      ((filt & ~prev_q & rise_q) | (~filt & prev_q & fall_q)) : '0;
    assign clr = (wr && bus.i_addr == 3'd6) ? wpins : '0;

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        irq_en_d   = irq_en_q;
        rise_d     = rise_q;
        fall_d     = fall_q;
        status_d   = (status_q & ~clr) | edge_set;
        if (wr) begin
            case (bus.i_addr)
                3'd0:    data_out_d = wpins;
                3'd1:    dir_d      = wpins;
                3'd3:    irq_en_d   = wpins;
                3'd4:    rise_d     = wpins;
                3'd5:    fall_d     = wpins;
                3'd7:    data_out_d = data_out_q ^ wpins;
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (accept) begin
            rdata_d = '0;
            if (!bus.i_we) begin
                case (bus.i_addr)
                    3'd0:    rdata_d = 32'(data_out_q);
                    3'd1:    rdata_d = 32'(dir_q);
                    3'd2:    rdata_d = 32'(filt);
                    3'd3:    rdata_d = 32'(irq_en_q);
                    3'd4:    rdata_d = 32'(rise_q);
                    3'd5:    rdata_d = 32'(fall_q);
                    3'd6:    rdata_d = 32'(status_q);
                    default: rdata_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_out_q <= '0;
            dir_q      <= '0;
            irq_en_q   <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            status_q   <= '0;
            prev_q     <= '0;
            guard_q    <= '0;
            ack_q      <= 1'b0;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            irq_en_q   <= irq_en_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            status_q   <= status_d;
            prev_q     <= filt;
            if (guard_q != GUARD_END) guard_q <= guard_q + 1'b1;
            ack_q      <= accept;
            irq_q      <= |(status_q & irq_en_q);
            rdata_q    <= rdata_d;
        end
    end

    assign o_gpio      = data_out_q;
    assign en_gpio     = dir_q;
    assign o_irq       = irq_q;
    assign bus.o_ack   = ack_q;
    assign bus.o_rdata = rdata_q;
endmodule
